// File: rtl/vga_sync_if.sv
// vga_sync_if: pixel enable in, scan position and timing strobes out
interface vga_sync_if;
  logic       pixEn;
  logic [9:0] widthVgaPos;
  logic [9:0] heightVgaPos;
  logic [3:0] widthMemPos;
  logic [3:0] heightMemPos;
  logic       hsync;
  logic       vsync;
  logic       videoOn;
  logic       frameStart;
  modport master (
    input  pixEn,
    output widthVgaPos, heightVgaPos, widthMemPos, heightMemPos,
    output hsync, vsync, videoOn, frameStart
  );
  modport slave (
    output pixEn,
    input  widthVgaPos, heightVgaPos, widthMemPos, heightMemPos,
    input  hsync, vsync, videoOn, frameStart
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA scan counters, syncs, display enable and memory block coordinates
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int BLOCK_W   = 40,
  parameter int BLOCK_H   = 40,
  parameter bit SYNC_POL  = 1'b0
) (
  input logic       clk,
  input logic       rst,
  vga_sync_if.master vga
);
  localparam logic [9:0] X_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] X_VLAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] HS_ON   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_OFF  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] Y_VLAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS_ON   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_OFF  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [5:0] BW_LAST = 6'(BLOCK_W - 1);
  localparam logic [5:0] BH_LAST = 6'(BLOCK_H - 1);
  logic [9:0] x, y, x_n, y_n;
  logic [5:0] hsub, vsub, hsub_n, vsub_n;
  logic [3:0] col, row, col_n, row_n;
  logic       line_end;
  // next scan position; block trackers clear from the last visible pixel/line through blanking
  always_comb begin
    line_end = x == X_LAST;
    x_n      = line_end ? '0 : x + 10'd1;
    y_n      = line_end ? (y == Y_LAST ? '0 : y + 10'd1) : y;
    hsub_n   = (x >= X_VLAST || hsub == BW_LAST) ? '0 : hsub + 6'd1;
    col_n    = x >= X_VLAST ? '0 : hsub == BW_LAST ? col + 4'd1 : col;
    vsub_n   = !line_end ? vsub : (y >= Y_VLAST || vsub == BH_LAST) ? '0 : vsub + 6'd1;
    row_n    = !line_end ? row : y >= Y_VLAST ? '0 : vsub == BH_LAST ? row + 4'd1 : row;
  end
  // state and strobes advance together so every output describes the same pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      x              <= '0;
      y              <= '0;
      hsub           <= '0;
      vsub           <= '0;
      col            <= '0;
      row            <= '0;
      vga.hsync      <= !SYNC_POL;
      vga.vsync      <= !SYNC_POL;
      vga.videoOn    <= 1'b1;
      vga.frameStart <= 1'b1;
    end else if (vga.pixEn) begin
      x              <= x_n;
      y              <= y_n;
      hsub           <= hsub_n;
      vsub           <= vsub_n;
      col            <= col_n;
      row            <= row_n;
      vga.hsync      <= (x_n >= HS_ON && x_n <= HS_OFF) ? SYNC_POL : !SYNC_POL;
      vga.vsync      <= (y_n >= VS_ON && y_n <= VS_OFF) ? SYNC_POL : !SYNC_POL;
      vga.videoOn    <= x_n <= X_VLAST && y_n <= Y_VLAST;
      vga.frameStart <= x_n == '0 && y_n == '0;
    end
  end
  assign vga.widthVgaPos  = x;
  assign vga.heightVgaPos = y;
  assign vga.widthMemPos  = col;
  assign vga.heightMemPos = row;
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel timing generator for the 640x480@60 Hz VGA path. It produces the scan position that the VGA-to-memory adapter consumes.
- Drives horizontal/vertical counters, sync pulses and a display-enable signal.
- Also tracks the 16x12 video-memory block coordinates incrementally, using sub-block counters instead of comparators.
- Sits between the board clock/tick divider and the adapter/colour output stage.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels); line total 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines); frame total 525
- BLOCK_W, 40, pixels per memory block horizontally
- BLOCK_H, 40, lines per memory block vertically
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- pixEn  input  1  pixel-rate clock enable; all state advances only on clk edges with pixEn=1
- widthVgaPos  output  10  current horizontal count, 0..799
- heightVgaPos  output  10  current vertical count, 0..524
- widthMemPos  output  4  block column, 0..15; 0 outside visible columns
- heightMemPos  output  4  block row, 0..11; 0 outside visible lines
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- videoOn  output  1  high when x<640 and y<480
- frameStart  output  1  high for the pixel period at (0,0)

Behaviour:
- Clocking and reset: one clock, reset synchronous and active-high. All outputs are registered.
  - On rst=1 (regardless of pixEn): x=0, y=0, sub-block counters=0, widthMemPos=0, heightMemPos=0.
  - Also on reset: hsync=vsync=!SYNC_POL (inactive), videoOn=1, frameStart=1. Outputs are consistent with position (0,0).
  - Reset mid-frame returns to (0,0) on the next edge.
- Horizontal counter: increments on pixEn. At x=799 it wraps to 0 and increments y.
- Vertical counter: at x=799, y=524 both wrap to 0.
- pixEn=0: every register holds. There is no partial update.
- Horizontal block tracking: a sub-counter runs 0..BLOCK_W-1.
  - On the pixel where the sub-counter=BLOCK_W-1 and x<H_VISIBLE-1, widthMemPos increments and the sub-counter clears.
  - When x goes 639->640, widthMemPos and the sub-counter clear and stay 0 through blanking. Line start therefore begins at column 0.
  - Required mapping: widthMemPos == floor(x/40) for x<640.
- Vertical block tracking: same scheme on line boundaries (x=799), giving heightMemPos == floor(y/40) for y<480.
  - Clears at y 479->480 and on frame wrap.
- Sync timing:
  - hsync is active (=SYNC_POL) exactly for x in [656,751].
  - vsync is active exactly for y in [490,491], for all x of those lines.
- Alignment:
  - All outputs describe the same pixel in the same cycle; there is zero skew between position, syncs and videoOn.
  - Sync/enable registers are computed from the next-state counter values.
- frameStart: asserted exactly while x=0 and y=0, i.e. one pixel period (4 clk at pixEn 1-in-4).
- Widths: counters are 10-bit; no value beyond 799/524 is ever reachable. Block outputs never exceed 15/11.
- Simultaneous line and frame wrap: y wraps and x wraps on the same edge, and both block rows/cols reset.

Test Plan:
- Reset: assert rst 3 clk with pixEn=1 -> x=0, y=0, widthMemPos=0, heightMemPos=0, hsync=1, vsync=1, videoOn=1, frameStart=1. Release -> next pixEn edge gives x=1, frameStart=0.
- Column mapping: sweep line 0 -> widthMemPos=0 at x=39, 1 at x=40, 15 at x=639, 0 at x=640..799. videoOn falls at x=640.
- Hsync window: hsync=1 at x=655, 0 at x=656..751, 1 at x=752. At x=799, the next step gives x=0, y=1.
- Rows/vsync: y=39->40 changes heightMemPos 0->1; y=479 gives row 11, y=480 gives row 0. vsync=0 only on y=490,491. At (799,524) the next step gives (0,0) with frameStart=1.
- Enable gating: pixEn pattern 1-in-4 -> each position held exactly 4 clk. pixEn=0 for 100 clk mid-line -> no output changes.
- Mid-frame reset: at (700,300) assert rst 1 clk -> next cycle (0,0), block 0/0, syncs inactive. A full frame afterwards is 800*525 pixEn pulses.
